// File: rtl/nor_bus_cycle_if.sv
// nor_bus_cycle_if: request handshake and flash strobe/address signals of the
// NOR bus cycle engine. The flash data bus stays a plain inout on the module.
// Optional feature: NOR_STATUS_POLL_EN adds the POLL request qualifier.
interface nor_bus_cycle_if;
  // request side
  logic        REQ;
  logic        RW;
  logic [23:0] A_IN;
  logic [15:0] D_IN;
`ifdef NOR_STATUS_POLL_EN
  logic        POLL;
`endif
  logic        ACK;
  logic        BUSY;
  logic [15:0] D_OUT;
  logic        TIMEOUT;
  // flash side
  logic        CE;
  logic        WE;
  logic        OE;
  logic [23:0] ADDR;

  // command sequencer / bench view
  modport master (
`ifdef NOR_STATUS_POLL_EN
    output POLL,
`endif
    output REQ, RW, A_IN, D_IN,
    input  ACK, BUSY, D_OUT, TIMEOUT, CE, WE, OE, ADDR
  );

  // bus cycle engine view
  modport slave (
`ifdef NOR_STATUS_POLL_EN
    input  POLL,
`endif
    input  REQ, RW, A_IN, D_IN,
    output ACK, BUSY, D_OUT, TIMEOUT, CE, WE, OE, ADDR
  );
endinterface

// File: rtl/nor_bus_cycle.sv
// nor_bus_cycle: generates one NOR flash read or write bus cycle per request
// with programmable setup / strobe / hold lengths. All outputs are registered.
// Optional feature: define NOR_STATUS_POLL_EN to enable status polling, where a
// read with POLL=1 repeats until DATA[7]=1 or POLL_LIMIT reads have been made.
module nor_bus_cycle #(
  parameter int unsigned T_SETUP    = 1,
  parameter int unsigned T_PULSE    = 3,
  parameter int unsigned T_HOLD     = 1,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic           CLK,
  input  logic           RESET,
  nor_bus_cycle_if.slave bus,
  inout  wire [15:0]     DATA
);

  localparam int unsigned T_SP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned T_MAX = (T_SP > T_HOLD) ? T_SP : T_HOLD;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    DONE
`ifdef NOR_STATUS_POLL_EN
    , GAP
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          ce_q;
  logic          we_q;
  logic          oe_q;
  logic          ack_q;
  logic          busy_q;
  logic          rw_q;
  logic          data_oe;
  logic [23:0]   addr_q;
  logic [15:0]   wdata_q;
  logic [15:0]   dout_q;
`ifdef NOR_STATUS_POLL_EN
  logic          poll_q;
  logic          timeout_q;
  logic [15:0]   rd_cnt;
`endif

  // Bus cycle sequencer: every output is set on the edge that enters the state
  // it belongs to, so strobes and data enables come straight from flops.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      tcnt      <= '0;
      ce_q      <= 1'b1;
      we_q      <= 1'b1;
      oe_q      <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      data_oe   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
`ifdef NOR_STATUS_POLL_EN
      poll_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_cnt    <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            addr_q    <= bus.A_IN;
            wdata_q   <= bus.D_IN;
            rw_q      <= bus.RW;
            data_oe   <= !bus.RW;
            ce_q      <= 1'b0;
            busy_q    <= 1'b1;
            tcnt      <= '0;
            state     <= SETUP;
`ifdef NOR_STATUS_POLL_EN
            // a poll qualifier on a write is dropped: it runs as a plain write
            poll_q    <= bus.POLL && bus.RW;
            timeout_q <= 1'b0;
            rd_cnt    <= '0;
`endif
          end
        end
        SETUP: begin
          if (tcnt == CW'(T_SETUP - 1)) begin
            tcnt  <= '0;
            state <= PULSE;
            if (rw_q) oe_q <= 1'b0;
            else      we_q <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        PULSE: begin
          if (tcnt == CW'(T_PULSE - 1)) begin
            tcnt  <= '0;
            state <= HOLD;
            we_q  <= 1'b1;
            oe_q  <= 1'b1;
            if (rw_q) begin
              dout_q <= DATA;
`ifdef NOR_STATUS_POLL_EN
              if (poll_q) rd_cnt <= rd_cnt + 16'd1;
`endif
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          if (tcnt == CW'(T_HOLD - 1)) begin
            tcnt    <= '0;
            ce_q    <= 1'b1;
            data_oe <= 1'b0;
`ifdef NOR_STATUS_POLL_EN
            // D_OUT already holds this read's status; a ready bit beats the limit
            if (poll_q && !dout_q[7] && (rd_cnt != 16'(POLL_LIMIT))) begin
              state <= GAP;
            end else begin
              state     <= DONE;
              ack_q     <= 1'b1;
              timeout_q <= poll_q && !dout_q[7];
            end
`else
            state <= DONE;
            ack_q <= 1'b1;
`endif
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
`ifdef NOR_STATUS_POLL_EN
        GAP: begin
          ce_q  <= 1'b0;
          tcnt  <= '0;
          state <= SETUP;
        end
`endif
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign DATA      = data_oe ? wdata_q : 'z;
  assign bus.CE    = ce_q;
  assign bus.WE    = we_q;
  assign bus.OE    = oe_q;
  assign bus.ADDR  = addr_q;
  assign bus.ACK   = ack_q;
  assign bus.BUSY  = busy_q;
  assign bus.D_OUT = dout_q;
`ifdef NOR_STATUS_POLL_EN
  assign bus.TIMEOUT = timeout_q;
`else
  assign bus.TIMEOUT = 1'b0;
  // the poll limit only matters when polling is built in
  logic unused_poll_limit;
  assign unused_poll_limit = ^16'(POLL_LIMIT);
`endif

endmodule

// File: tb/tb_nor_bus_cycle.sv
// tb_nor_bus_cycle: scoreboard bench for nor_bus_cycle. Each request pushes its
// expected completion; a cycle monitor accumulates strobe/data activity and
// compares everything when ACK appears. Poll scenarios need NOR_STATUS_POLL_EN.
module tb_nor_bus_cycle;

  localparam int TS = 1;
  localparam int TP = 3;
  localparam int TH = 1;
  localparam int TC = TS + TP + TH;
`ifdef NOR_STATUS_POLL_EN
  localparam int PL = 4;
`else
  localparam int PL = 1024;
`endif

  typedef struct {
    logic        rw;
    logic        poll;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout;
    logic        tmo;
    int          n_acc;
    int          gap;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  tri1  [15:0] DATA;

  nor_bus_cycle_if bus ();

  nor_bus_cycle #(
    .T_SETUP   (TS),
    .T_PULSE   (TP),
    .T_HOLD    (TH),
    .POLL_LIMIT(PL)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus),
    .DATA (DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // flash model: drives the current status word while CE and OE are low
  logic [15:0] flash_val = 16'h0000;
  logic [15:0] status_q[$];
  assign DATA = (!bus.CE && !bus.OE) ? flash_val : 'z;

  exp_t        sb[$];
  logic [15:0] last_dout = 16'h0000;
  int n_tests = 0;
  int n_fail  = 0;
  int ce_n, we_n, oe_n, ovl_n, acc_n, drv_n, bad_n;
  int acc_cyc, acc_gap, last_ack_cyc;
  logic ce_prev, busy_prev;
  logic [15:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    ce_n = 0; we_n = 0; oe_n = 0; ovl_n = 0; acc_n = 0; drv_n = 0; bad_n = 0;
  endtask

  task automatic flash_model();
    forever begin
      @(negedge bus.OE);
      if (status_q.size() > 0) flash_val = status_q.pop_front();
    end
  endtask

  task automatic monitor();
    exp_t it;
    clear_counts();
    ce_prev = 1'b1; busy_prev = 1'b0; last_ack_cyc = 0; acc_cyc = 0; acc_gap = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        clear_counts();
        ce_prev = 1'b1;
        busy_prev = 1'b0;
      end else begin
        if (bus.BUSY && !busy_prev) begin
          acc_cyc = cyc;
          acc_gap = cyc - last_ack_cyc;
        end
        if (!bus.CE) ce_n++;
        if (!bus.WE) we_n++;
        if (!bus.OE) oe_n++;
        if (!bus.WE && !bus.OE) ovl_n++;
        if (!bus.CE && ce_prev) acc_n++;
        if (!bus.CE && !bus.OE) mon_exp = flash_val;
        else if (sb.size() > 0 && !sb[0].rw && !bus.CE) mon_exp = sb[0].wdata;
        else mon_exp = 16'hFFFF;
        if (DATA !== mon_exp) bad_n++;
        if (!(!bus.CE && !bus.OE) && DATA !== 16'hFFFF) drv_n++;
        if (bus.ACK) begin
          if (sb.size() == 0) begin
            check("ack_unexp", 32'(bus.ACK), 0);
          end else begin
            it = sb.pop_front();
            check("ack_busy", 32'(bus.BUSY), 1);
            check("ack_ce", 32'(bus.CE), 1);
            check("ack_addr", 32'(bus.ADDR), 32'(it.addr));
            check("ack_dout", 32'(bus.D_OUT), 32'(it.dout));
            check("ack_timeout", 32'(bus.TIMEOUT), 32'(it.tmo));
            check("lat", 32'(cyc - acc_cyc), 32'(it.n_acc * TC + it.n_acc - 1));
            check("accesses", 32'(acc_n), 32'(it.n_acc));
            check("ce_cycles", 32'(ce_n), 32'(it.n_acc * TC));
            check("we_cycles", 32'(we_n), it.rw ? 0 : TP);
            check("oe_cycles", 32'(oe_n), it.rw ? 32'(it.n_acc * TP) : 0);
            check("dut_drive_cycles", 32'(drv_n), it.rw ? 0 : TC);
            check("data_bad_cycles", 32'(bad_n), 0);
            check("we_oe_overlap", 32'(ovl_n), 0);
            if (it.gap != 0) check("b2b_gap", 32'(acc_gap), 32'(it.gap));
            last_ack_cyc = cyc;
            clear_counts();
          end
        end
        ce_prev = bus.CE;
        busy_prev = bus.BUSY;
      end
    end
  endtask

  task automatic push_exp(input logic rw, input logic [23:0] a, input logic [15:0] d,
                          input logic poll, input logic [15:0] rdv, input int n_acc,
                          input logic tmo, input int gap);
    exp_t it;
    it.rw = rw; it.poll = poll; it.addr = a; it.wdata = d;
    it.dout = rw ? rdv : last_dout;
    it.tmo = tmo; it.n_acc = n_acc; it.gap = gap;
    last_dout = it.dout;
    sb.push_back(it);
  endtask

  // drives a request at the current negedge and confirms acceptance one edge later
  task automatic start_op(input logic rw, input logic [23:0] a, input logic [15:0] d,
                          input logic poll, input logic [15:0] rdv, input int n_acc,
                          input logic tmo);
    push_exp(rw, a, d, poll, rdv, n_acc, tmo, 0);
    bus.REQ = 1'b1; bus.RW = rw; bus.A_IN = a; bus.D_IN = d;
`ifdef NOR_STATUS_POLL_EN
    bus.POLL = poll;
`endif
    @(negedge CLK);
    check("accept", 32'(bus.BUSY), 1);
    bus.REQ = 1'b0; bus.RW = ~rw; bus.A_IN = ~a; bus.D_IN = ~d;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(sb.size()), 0);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.REQ = 1'b0; bus.RW = 1'b0; bus.A_IN = '0; bus.D_IN = '0;
`ifdef NOR_STATUS_POLL_EN
    bus.POLL = 1'b0;
`endif
    fork
      monitor();
      flash_model();
    join_none

    // reset state
    @(negedge CLK); @(negedge CLK);
    check("rst_ce", 32'(bus.CE), 1);
    check("rst_we", 32'(bus.WE), 1);
    check("rst_oe", 32'(bus.OE), 1);
    check("rst_ack", 32'(bus.ACK), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_timeout", 32'(bus.TIMEOUT), 0);
    check("rst_addr", 32'(bus.ADDR), 0);
    check("rst_dout", 32'(bus.D_OUT), 0);
    check("rst_data_z", 32'(DATA), 32'hFFFF);
    RESET = 1'b1;
    @(negedge CLK);

    // plain write and read cycles
    start_op(1'b0, 24'h000555, 16'h00AA, 1'b0, 16'h0000, 1, 1'b0);
    drain("drain_wr");
    status_q.push_back(16'h0089);
    start_op(1'b1, 24'h000000, 16'h0000, 1'b0, 16'h0089, 1, 1'b0);
    drain("drain_rd");
    start_op(1'b0, 24'hABCDEF, 16'h1234, 1'b0, 16'h0000, 1, 1'b0);
    drain("drain_wr2");
    status_q.push_back(16'hFF7E);
    start_op(1'b1, 24'hFFFFFF, 16'h0000, 1'b0, 16'hFF7E, 1, 1'b0);
    drain("drain_rd2");
    start_op(1'b0, 24'h000001, 16'h0001, 1'b0, 16'h0000, 1, 1'b0);
    drain("drain_wr3");

    // back-to-back writes with REQ held; input churn while busy is ignored
    push_exp(1'b0, 24'h000555, 16'h00AA, 1'b0, 16'h0000, 1, 1'b0, 0);
    bus.REQ = 1'b1; bus.RW = 1'b0; bus.A_IN = 24'h000555; bus.D_IN = 16'h00AA;
    @(negedge CLK);
    check("b2b_accept1", 32'(bus.BUSY), 1);
    bus.REQ = 1'b0; bus.RW = 1'b1; bus.A_IN = 24'h123456; bus.D_IN = 16'hDEAD;
    @(negedge CLK);
    bus.REQ = 1'b1;
    @(negedge CLK);
    push_exp(1'b0, 24'h0002AA, 16'h0055, 1'b0, 16'h0000, 1, 1'b0, 2);
    bus.RW = 1'b0; bus.A_IN = 24'h0002AA; bus.D_IN = 16'h0055;
    n = 0;
    while (bus.BUSY !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_idle", 32'(bus.BUSY), 0);
    @(negedge CLK);
    check("b2b_accept2", 32'(bus.BUSY), 1);
    bus.REQ = 1'b0;
    drain("drain_b2b");

    // reset in the middle of a write strobe
    start_op(1'b0, 24'h0000F0, 16'h3C3C, 1'b0, 16'h0000, 1, 1'b0);
    n = 0;
    while (bus.WE !== 1'b0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("mid_we_low", 32'(bus.WE), 0);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    sb.delete();
    last_dout = 16'h0000;
    #1;
    check("mid_rst_ce", 32'(bus.CE), 1);
    check("mid_rst_we", 32'(bus.WE), 1);
    check("mid_rst_data_z", 32'(DATA), 32'hFFFF);
    check("mid_rst_busy", 32'(bus.BUSY), 0);
    check("mid_rst_ack", 32'(bus.ACK), 0);
    check("mid_rst_addr", 32'(bus.ADDR), 0);
    check("mid_rst_dout", 32'(bus.D_OUT), 0);
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b1;
    start_op(1'b0, 24'h000AAA, 16'h5555, 1'b0, 16'h0000, 1, 1'b0);
    drain("drain_after_rst");

`ifdef NOR_STATUS_POLL_EN
    // poll that becomes ready on the fourth read
    status_q.push_back(16'h0000);
    status_q.push_back(16'h0000);
    status_q.push_back(16'h0000);
    status_q.push_back(16'h0080);
    start_op(1'b1, 24'h000AAA, 16'h0000, 1'b1, 16'h0080, 4, 1'b0);
    drain("drain_poll_ok");
    check("poll_ok_timeout", 32'(bus.TIMEOUT), 0);
    // poll that never becomes ready
    for (int i = 0; i < PL; i++) status_q.push_back(16'h0000);
    start_op(1'b1, 24'h000555, 16'h0000, 1'b1, 16'h0000, PL, 1'b1);
    drain("drain_poll_to");
    check("timeout_held", 32'(bus.TIMEOUT), 1);
    // poll qualifier on a write runs as a plain write and clears TIMEOUT
    start_op(1'b0, 24'h000123, 16'hBEEF, 1'b1, 16'h0000, 1, 1'b0);
    drain("drain_poll_wr");
`endif

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_bus_cycle.md
NOR_BUS_CYCLE -- requirements
Module: nor_bus_cycle

Interface
REQ-001 Parameter T_SETUP, default 1: cycles with CE low and address/data stable before the WE or OE strobe; legal range >=1.
REQ-002 Parameter T_PULSE, default 3: cycles with the WE or OE strobe low; legal range >=1.
REQ-003 Parameter T_HOLD, default 1: cycles with CE low after the strobe rises; legal range >=1.
REQ-004 Parameter POLL_LIMIT, default 1024: maximum status reads per poll operation; legal range 1..65535.
REQ-005 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 REQ  input  1  operation request from the command sequencer; sampled only in IDLE.
REQ-008 RW  input  1  1 = read cycle, 0 = write cycle.
REQ-009 A_IN  input  24  word address of the request.
REQ-010 D_IN  input  16  write data.
REQ-011 POLL  input  1  1 = status-poll operation; present only with NOR_STATUS_POLL_EN.
REQ-012 ACK  output  1  one-cycle completion pulse.
REQ-013 BUSY  output  1  high from request acceptance through the ACK cycle.
REQ-014 D_OUT  output  16  read data captured on the last read.
REQ-015 TIMEOUT  output  1  poll limit reached; valid during the ACK cycle.
REQ-016 CE, WE, OE  output  1 each  flash strobes, active-low.
REQ-017 ADDR  output  24  flash address.
REQ-018 DATA  inout  16  flash data bus.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, PULSE, HOLD, DONE, plus GAP with the macro.
REQ-020 In IDLE with REQ=1 at edge k: latch A_IN, D_IN and RW (and POLL); assert CE=0 and BUSY=1; drive ADDR; enter SETUP.
REQ-021 The block SHALL remain T_SETUP cycles in SETUP, T_PULSE cycles in PULSE, T_HOLD cycles in HOLD, then one cycle in DONE.
REQ-022 ACK SHALL be 1 only in DONE, first visible after edge k+T_SETUP+T_PULSE+T_HOLD (edge k+5 with defaults).
REQ-023 In DONE: CE=1, BUSY=1; the next edge returns to IDLE, so BUSY=0 and back-to-back requests are spaced at least one IDLE cycle apart.
REQ-024 In PULSE: WE=0 for writes, OE=0 for reads; the other strobe stays 1; WE and OE SHALL never be 0 simultaneously.
REQ-025 DATA SHALL be driven with the latched D_IN in SETUP, PULSE and HOLD of write cycles only; otherwise DATA is high-Z.
REQ-026 D_OUT SHALL capture DATA at the final PULSE edge of a read and hold it until the next read capture.
REQ-027 REQ, A_IN, D_IN, RW and POLL SHALL be ignored outside IDLE; ADDR SHALL hold the latched address until the next acceptance.

Reset
REQ-028 RESET=0 SHALL asynchronously force: state IDLE; CE=WE=OE=1; DATA high-Z; ACK=0; BUSY=0; TIMEOUT=0; ADDR=0; D_OUT=0; poll counter=0.
REQ-029 Reset during any state SHALL abort the cycle with no ACK; after RESET=1, the first REQ is accepted at the next edge.

Configuration
REQ-030 With NOR_STATUS_POLL_EN defined, a read request with POLL=1 SHALL repeat the read cycles at the latched address; after each HOLD, the FSM enters GAP (CE=1, one cycle) and then SETUP again.
REQ-031 Polling SHALL stop after the read where D_OUT[7]=1 (DONE, TIMEOUT=0) or after the POLL_LIMIT-th read (DONE, TIMEOUT=1).
REQ-032 The 16-bit read counter SHALL clear on acceptance.
REQ-033 TIMEOUT SHALL be held until the next acceptance.
REQ-034 A poll request with RW=0 SHALL be executed as a plain write.
REQ-035 Without NOR_STATUS_POLL_EN, the POLL port, the GAP state and the counter SHALL be absent, and TIMEOUT SHALL be tied to 0.

Verification
REQ-036 Write: REQ, RW=0, A_IN=0x000555, D_IN=0x00AA -> CE low for 5 cycles, WE low for 3 cycles, DATA=0x00AA for 5 cycles, ACK at k+5, OE always 1.
REQ-037 Read: model returns 0x0089 at 0x000000 -> OE low for 3 cycles, D_OUT=0x0089 at ACK, DATA never driven by the DUT.
REQ-038 Back-to-back: REQ held high for two writes -> the second CE falling edge follows DONE by exactly one IDLE cycle; REQ changes during BUSY have no effect.
REQ-039 Reset mid-PULSE of a write -> CE=WE=1 and DATA=Z in the same cycle, no ACK; the next REQ completes normally.
REQ-040 Poll (macro on): status reads 0x0000 x3 then 0x0080 -> 4 read cycles separated by CE-high gaps, ACK with D_OUT=0x0080, TIMEOUT=0.
REQ-041 Poll (macro on, POLL_LIMIT=4): status stays 0x0000 -> exactly 4 reads, ACK with TIMEOUT=1.
